// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: processes WIDTH-bit operands LSB-first through a
// BITS_PER_CYCLE-wide ripple slice, with start/busy/done handshake and overflow flag.
module serial_adder #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  generate
    if (WIDTH < 2 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
      $error("serial_adder: BITS_PER_CYCLE must divide WIDTH and WIDTH must be >= 2");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic [CW-1:0]      step_q, step_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [BITS_PER_CYCLE-1:0] slice_sum;
  logic                      slice_cout;
  logic                      slice_cmsb;
  logic                      ripple;

  // slice_cmsb is the carry entering the slice's top bit; on the last step that
  // is the carry into bit WIDTH-1, needed for the signed-overflow flag.
  always_comb begin
    ripple     = carry_q;
    slice_sum  = '0;
    slice_cmsb = 1'b0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (i == BITS_PER_CYCLE - 1) slice_cmsb = ripple;
      slice_sum[i] = a_q[i] ^ b_q[i] ^ ripple;
      ripple       = (a_q[i] & b_q[i]) | (ripple & (a_q[i] ^ b_q[i]));
    end
    slice_cout = ripple;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    step_d  = step_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          step_d  = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        a_d     = a_q >> BITS_PER_CYCLE;
        b_d     = b_q >> BITS_PER_CYCLE;
        res_d   = WIDTH'({slice_sum, res_q} >> BITS_PER_CYCLE);
        carry_d = slice_cout;
        step_d  = step_q + CW'(1);
        if (step_q == LAST_STEP) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          sum_d   = res_d;
          cout_d  = slice_cout;
          ovf_d   = slice_cmsb ^ slice_cout;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      step_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: 8-bit at 1 and 4 bits/cycle, plus an
// exhaustive 3-bit sweep of all operand/carry/mode combinations.
module tb_serial_adder;

   logic clk;
   logic rst_n;

   logic       start8, cin8, sub8;
   logic [7:0] a8, b8;
   logic       busy8, done8, cout8, ovf8;
   logic [7:0] sum8;

   logic       start4, cin4, sub4;
   logic [7:0] a4, b4;
   logic       busy4, done4, cout4, ovf4;
   logic [7:0] sum4;

   logic       start3, cin3, sub3;
   logic [2:0] a3, b3;
   logic       busy3, done3, cout3, ovf3;
   logic [2:0] sum3;

   int checkCount = 0;
   int failCount  = 0;
   int cnt;
   int busyCycles;
   int doneSeen;
   int busySeen;

   serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8));

   serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4));

   serial_adder #(.WIDTH(3), .BITS_PER_CYCLE(1)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .cin(cin3), .sub(sub3),
      .busy(busy3), .done(done3), .sum(sum3), .cout(cout3), .ovf(ovf3));

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: counts it and reports any difference as a FAIL line.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Starts an operation on the 1-bit/cycle adder; returns #1 after the accepting edge.
   task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic c, input logic s);
      a8 = av; b8 = bv; cin8 = c; sub8 = s; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
   endtask

   // Counts edges until done8 rises, with a cycle bound.
   task automatic waitDone8(output int edges, output int busyN);
      edges = 0;
      busyN = 1;
      while (done8 !== 1'b1 && edges < 40) begin
         @(posedge clk); #1;
         edges++;
         if (busy8 === 1'b1) busyN++;
      end
   endtask

   task automatic waitDone4(output int edges);
      edges = 0;
      while (done4 !== 1'b1 && edges < 40) begin
         @(posedge clk); #1;
         edges++;
      end
   endtask

   // Exhaustive 3-bit operation with an independent arithmetic model.
   task automatic run3(input int av, input int bv, input int c, input int s);
      int r, sa, sb, sr, expOvf, edges;
      a3 = 3'(av); b3 = 3'(bv); cin3 = c[0]; sub3 = s[0]; start3 = 1'b1;
      @(posedge clk); #1;
      start3 = 1'b0;
      edges = 0;
      while (done3 !== 1'b1 && edges < 20) begin
         @(posedge clk); #1;
         edges++;
      end
      sa = (av > 3) ? av - 8 : av;
      sb = (bv > 3) ? bv - 8 : bv;
      if (s != 0) begin
         r  = av + (7 - bv) + 1;
         sr = sa - sb;
      end else begin
         r  = av + bv + c;
         sr = sa + sb + c;
      end
      expOvf = (sr > 3 || sr < -4) ? 1 : 0;
      checkOutput($sformatf("w3 a=%0d b=%0d cin=%0d sub=%0d {done,ovf,cout,sum}", av, bv, c, s),
                  {27'd0, done3, ovf3, cout3, sum3},
                  {27'd0, 1'b1, expOvf[0], r[3], r[2:0]});
   endtask

   initial begin
      rst_n = 1'b0;
      start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
      start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;
      start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0; sub3 = 1'b0;

      #12;
      checkOutput("reset busy", busy8, 0);
      checkOutput("reset done", done8, 0);
      checkOutput("reset sum", sum8, 0);
      checkOutput("reset cout/ovf", {cout8, ovf8}, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 0x5A + 0x33 = 0x8D, signed overflow (90 + 51 > 127)
      applyStimulus(8'h5A, 8'h33, 1'b0, 1'b0);
      checkOutput("add1 busy after accept", busy8, 1);
      checkOutput("add1 sum held before done", sum8, 0);
      waitDone8(cnt, busyCycles);
      checkOutput("add1 done latency", cnt, 8);
      checkOutput("add1 busy cycles", busyCycles, 8);
      checkOutput("add1 busy low at done", busy8, 0);
      checkOutput("add1 sum", sum8, 8'h8D);
      checkOutput("add1 cout", cout8, 0);
      checkOutput("add1 ovf", ovf8, 1);
      @(posedge clk); #1;
      checkOutput("add1 done single pulse", done8, 0);
      checkOutput("add1 sum holds", sum8, 8'h8D);

      // 0x10 - 0x20 = 0xF0 with borrow
      applyStimulus(8'h10, 8'h20, 1'b0, 1'b1);
      waitDone8(cnt, busyCycles);
      checkOutput("sub1 sum", sum8, 8'hF0);
      checkOutput("sub1 cout", cout8, 0);
      checkOutput("sub1 ovf", ovf8, 0);

      // 0x80 - 0x01 = 0x7F, no borrow, signed overflow; cin must be ignored
      applyStimulus(8'h80, 8'h01, 1'b1, 1'b1);
      waitDone8(cnt, busyCycles);
      checkOutput("sub2 sum", sum8, 8'h7F);
      checkOutput("sub2 cout", cout8, 1);
      checkOutput("sub2 ovf", ovf8, 1);

      // Asynchronous reset in cycle 4 of an operation
      applyStimulus(8'h5A, 8'h33, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midreset busy", busy8, 0);
      checkOutput("midreset sum", sum8, 0);
      checkOutput("midreset cout/ovf/done", {cout8, ovf8, done8}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      doneSeen = 0;
      busySeen = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done8 === 1'b1) doneSeen++;
         if (busy8 === 1'b1) busySeen++;
      end
      checkOutput("midreset no done after release", doneSeen, 0);
      checkOutput("midreset stays idle", busySeen, 0);
      applyStimulus(8'h10, 8'h20, 1'b1, 1'b0);
      waitDone8(cnt, busyCycles);
      checkOutput("post-reset latency", cnt, 8);
      checkOutput("post-reset sum", sum8, 8'h31);
      checkOutput("post-reset cout/ovf", {cout8, ovf8}, 0);

      // 0xFF + 0x00 + 1 wraps to 0 with carry; start pulsed mid-operation is ignored
      applyStimulus(8'hFF, 8'h00, 1'b1, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      a8 = 8'h01; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      waitDone8(cnt, busyCycles);
      checkOutput("ignore done latency", cnt, 5);
      checkOutput("ignore sum", sum8, 8'h00);
      checkOutput("ignore cout", cout8, 1);
      checkOutput("ignore ovf", ovf8, 0);
      doneSeen = 0;
      busySeen = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (done8 === 1'b1) doneSeen++;
         if (busy8 === 1'b1) busySeen++;
      end
      checkOutput("ignore no second done", doneSeen, 0);
      checkOutput("ignore no queued op", busySeen, 0);

      // 4 bits per cycle with start held high across the done cycle
      a4 = 8'h7F; b4 = 8'h01; cin4 = 1'b0; sub4 = 1'b0; start4 = 1'b1;
      @(posedge clk); #1;
      checkOutput("bpc4 busy after accept", busy4, 1);
      waitDone4(cnt);
      checkOutput("bpc4 done latency", cnt, 2);
      checkOutput("bpc4 sum", sum4, 8'h80);
      checkOutput("bpc4 cout", cout4, 0);
      checkOutput("bpc4 ovf", ovf4, 1);
      a4 = 8'h12; b4 = 8'h34;
      @(posedge clk); #1;
      start4 = 1'b0;
      checkOutput("bpc4 restart busy", busy4, 1);
      checkOutput("bpc4 restart done low", done4, 0);
      waitDone4(cnt);
      checkOutput("bpc4 second latency", cnt, 2);
      checkOutput("bpc4 second sum", sum4, 8'h46);
      checkOutput("bpc4 second cout/ovf", {cout4, ovf4}, 0);

      // Word-level truth-table sweep at WIDTH=3
      for (int s = 0; s < 2; s++)
         for (int c = 0; c < 2; c++)
            for (int av = 0; av < 8; av++)
               for (int bv = 0; bv < 8; bv++)
                  run3(av, bv, c, s);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
